// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the PC sequencer and its return-address stack.
package pc_sequencer_pkg;

    localparam int ADDR_W_DEFAULT      = 8;
    localparam int STACK_DEPTH_DEFAULT = 4;

    // Sequencer control state; encoding is fixed so checkers can decode it.
    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HALT = 2'b01
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO. Push and pop are ignored when they would overflow or
// underflow, so the count always stays in 0..DEPTH. Entry storage has no
// reset; o_top is forced to zero while empty so stale contents never leak.
module ret_stack
    import pc_sequencer_pkg::*;
#(
    parameter int W     = ADDR_W_DEFAULT,
    parameter int DEPTH = STACK_DEPTH_DEFAULT,
    localparam int IW   = $clog2(DEPTH),
    localparam int CW   = IW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_push_data,
    output logic [W-1:0]  o_top,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [CW-1:0] r_count;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty && !i_push;
    assign w_wr_idx  = r_count[IW-1:0];
    assign w_rd_idx  = r_count[IW-1:0] - IW'(1);
    assign o_count   = r_count;

    // Top of stack is only meaningful while non-empty.
    always_comb begin
        o_top = '0;
        if (!o_empty) begin
            o_top = r_mem[w_rd_idx];
        end
    end

    // Occupancy counter: one push or one pop per cycle at most.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + CW'(1);
        end else if (w_do_pop) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Entry storage; written only on an accepted push.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection: RUN/HALT control FSM, priority redirect mux and a
// return-address stack. next_address is combinational and is latched by the
// external PC register on the following rising edge.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT,
    localparam int CW         = $clog2(STACK_DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_atual,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_offset,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              call,
    input  logic              ret,
    input  logic              stall,
    input  logic              halt,
    input  logic              resume,
    output logic [ADDR_W-1:0] next_address,
    output logic              halted,
    output logic [CW-1:0]     stack_count,
    output logic              stack_overflow,
    output logic              stack_underflow,
    output seq_state_t        dbg_state
);

    seq_state_t        r_state;
    seq_state_t        w_state_next;
    logic              r_overflow;
    logic              r_underflow;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_branch;
    logic [ADDR_W-1:0] w_top;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_set_ovf;
    logic              w_set_unf;

    // Same-width addition gives the modulo-2^ADDR_W wrap and sign extension
    // of the displacement for free.
    assign w_pc_inc    = pc_atual + ADDR_W'(1);
    assign w_pc_branch = w_pc_inc + branch_offset;

    assign halted          = (r_state == HALT);
    assign stack_overflow  = r_overflow;
    assign stack_underflow = r_underflow;
    assign dbg_state       = r_state;

    ret_stack #(
        .W     (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .i_clk       (clock),
        .i_rst       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_inc),
        .o_top       (w_top),
        .o_count     (stack_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Control state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sticky stack error flags; only reset clears them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_set_ovf) r_overflow  <= 1'b1;
            if (w_set_unf) r_underflow <= 1'b1;
        end
    end

    // Next state, next address and stack requests in priority order.
    always_comb begin
        w_state_next = r_state;
        next_address = w_pc_inc;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_set_ovf    = 1'b0;
        w_set_unf    = 1'b0;
        case (r_state)
            RUN: begin
                if (halt) begin
                    w_state_next = HALT;
                    next_address = pc_atual;
                end else if (stall) begin
                    next_address = pc_atual;
                end else if (ret) begin
                    if (!w_empty) begin
                        next_address = w_top;
                        w_pop        = 1'b1;
                    end else begin
                        next_address = w_pc_inc;
                        w_set_unf    = 1'b1;
                    end
                end else if (call) begin
                    next_address = jump_target;
                    if (!w_full) begin
                        w_push = 1'b1;
                    end else begin
                        w_set_ovf = 1'b1;
                    end
                end else if (jump) begin
                    next_address = jump_target;
                end else if (branch_taken) begin
                    next_address = w_pc_branch;
                end
            end
            HALT: begin
                next_address = pc_atual;
                if (resume && !halt) begin
                    w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = RUN;
                next_address = pc_atual;
            end
        endcase
        // Reset forces the redirect to zero without waiting for a clock edge.
        if (reset) begin
            next_address = '0;
            w_push       = 1'b0;
            w_pop        = 1'b0;
            w_set_ovf    = 1'b0;
            w_set_unf    = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: inputs change just after the falling edge,
// combinational outputs are sampled 1 ns later, registered outputs after the
// following rising edge (again from the falling edge).
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int AW = 8;

    logic          clock;
    logic          reset;
    logic [AW-1:0] pc_atual;
    logic          branch_taken;
    logic [AW-1:0] branch_offset;
    logic          jump;
    logic [AW-1:0] jump_target;
    logic          call;
    logic          ret;
    logic          stall;
    logic          halt;
    logic          resume;
    logic [AW-1:0] next_address;
    logic          halted;
    logic [2:0]    stack_count;
    logic          stack_overflow;
    logic          stack_underflow;
    seq_state_t    dbg_state;

    int n_checks;
    int n_fail;

    pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .pc_atual        (pc_atual),
        .branch_taken    (branch_taken),
        .branch_offset   (branch_offset),
        .jump            (jump),
        .jump_target     (jump_target),
        .call            (call),
        .ret             (ret),
        .stall           (stall),
        .halt            (halt),
        .resume          (resume),
        .next_address    (next_address),
        .halted          (halted),
        .stack_count     (stack_count),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow),
        .dbg_state       (dbg_state)
    );

    // Clock generation.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_ctl();
        branch_taken  = 1'b0;
        branch_offset = '0;
        jump          = 1'b0;
        jump_target   = '0;
        call          = 1'b0;
        ret           = 1'b0;
        stall         = 1'b0;
        halt          = 1'b0;
        resume        = 1'b0;
    endtask

    // Move to just after the next falling edge, clear controls, set the PC.
    task automatic next_slot(input logic [AW-1:0] pc);
        @(negedge clock);
        clear_ctl();
        pc_atual = pc;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        clear_ctl();
        pc_atual = 8'h55;
        @(negedge clock);
        settle();
        check("rst_next", next_address, 0);
        check("rst_halted", halted, 0);
        check("rst_count", stack_count, 0);
        check("rst_ovf", stack_overflow, 0);
        check("rst_unf", stack_underflow, 0);
        check("rst_state", dbg_state, RUN);

        // Sequential wrap.
        next_slot(8'hFE);
        reset = 1'b0;
        settle();
        check("seq_fe", next_address, 8'hFF);
        next_slot(8'hFF);
        settle();
        check("seq_ff", next_address, 8'h00);

        // Branch with negative offset, then jump overriding it.
        next_slot(8'h10);
        branch_taken  = 1'b1;
        branch_offset = 8'hFC;
        settle();
        check("branch_neg", next_address, 8'h0D);
        jump        = 1'b1;
        jump_target = 8'h40;
        settle();
        check("jump_over_branch", next_address, 8'h40);

        // Single call / return.
        next_slot(8'h20);
        call        = 1'b1;
        jump_target = 8'h80;
        settle();
        check("call_next", next_address, 8'h80);
        next_slot(8'h80);
        check("call_count", stack_count, 1);
        pc_atual = 8'h85;
        ret      = 1'b1;
        settle();
        check("ret_next", next_address, 8'h21);
        next_slot(8'h86);
        check("ret_count", stack_count, 0);

        // Five calls at depth 4: pushes 0x01,0x11,0x21,0x31; fifth overflows.
        for (int i = 0; i < 5; i++) begin
            next_slot(AW'(i * 16));
            call        = 1'b1;
            jump_target = AW'(8'h80 + i);
            settle();
            check("ovf_call_next", next_address, 8'h80 + i);
        end
        next_slot(8'h90);
        check("ovf_count", stack_count, 4);
        check("ovf_flag", stack_overflow, 1);
        check("ovf_no_unf", stack_underflow, 0);
        for (int i = 0; i < 4; i++) begin
            ret = 1'b1;
            settle();
            check("ovf_ret_next", next_address, 8'h31 - 16 * i);
            next_slot(8'h90);
        end
        check("drain_count", stack_count, 0);
        check("drain_unf", stack_underflow, 0);
        ret = 1'b1;
        settle();
        check("unf_next", next_address, 8'h91);
        next_slot(8'h92);
        check("unf_flag", stack_underflow, 1);
        check("unf_count", stack_count, 0);
        check("ovf_sticky", stack_overflow, 1);

        // Stall beats ret.
        next_slot(8'h30);
        call        = 1'b1;
        jump_target = 8'h50;
        next_slot(8'h50);
        stall = 1'b1;
        ret   = 1'b1;
        settle();
        check("stall_next", next_address, 8'h50);
        next_slot(8'h50);
        check("stall_count", stack_count, 1);

        // Halt, ignore call while halted, halt+resume stays halted, resume.
        pc_atual = 8'h60;
        halt     = 1'b1;
        call     = 1'b1;
        settle();
        check("halt_next", next_address, 8'h60);
        next_slot(8'h61);
        check("halted_set", halted, 1);
        check("halt_state", dbg_state, HALT);
        call        = 1'b1;
        jump_target = 8'h99;
        settle();
        check("halt_call_ignored", next_address, 8'h61);
        next_slot(8'h61);
        check("halt_count", stack_count, 1);
        halt   = 1'b1;
        resume = 1'b1;
        next_slot(8'h61);
        check("halt_resume_both", halted, 1);
        resume = 1'b1;
        next_slot(8'h70);
        check("resumed", halted, 0);
        settle();
        check("resumed_seq", next_address, 8'h71);

        // Build count 3 and halted, then reset between edges.
        for (int i = 0; i < 2; i++) begin
            next_slot(AW'(8'hA0 + i));
            call        = 1'b1;
            jump_target = 8'hC0;
        end
        next_slot(8'hC0);
        halt = 1'b1;
        next_slot(8'hC0);
        check("pre_rst_count", stack_count, 3);
        check("pre_rst_halted", halted, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_next", next_address, 0);
        check("async_halted", halted, 0);
        check("async_count", stack_count, 0);
        check("async_ovf", stack_overflow, 0);
        check("async_unf", stack_underflow, 0);

        // After reset the old entries must not be returned.
        next_slot(8'h44);
        reset = 1'b0;
        ret   = 1'b1;
        settle();
        check("post_rst_ret", next_address, 8'h45);
        next_slot(8'h46);
        check("post_rst_unf", stack_underflow, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
